// File: rtl/ctrl_pipe_pkg.sv
// Shared opcode constants, ALUOp encodings and the EX control bundle type
// for the ID/EX control pipeline.
package ctrl_pipe_pkg;

  localparam logic [6:0] OP_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_IMME  = 7'b0010011;
  localparam logic [6:0] OP_I_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE       = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE       = 7'b1100011;
  localparam logic [6:0] OP_J_TYPE_JAL   = 7'b1101111;
  localparam logic [6:0] OP_J_TYPE_JALR  = 7'b1100111;
  localparam logic [6:0] OP_U_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_TYPE_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_IMM    = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    branch;
    logic    mem_to_regs;
    logic    mem_read;
    logic    mem_write;
    logic    alusrc;
    logic    regs_write;
    logic    illegal;
  } ex_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder producing the main control signals
// and the source-register usage flags consumed by hazard detection.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       mem_to_regs,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alusrc,
  output logic       regs_write,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       illegal
);

  always_comb begin
    alu_op      = ALU_ADD;
    branch      = 1'b0;
    mem_to_regs = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alusrc      = 1'b0;
    regs_write  = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    illegal     = 1'b0;
    unique case (opcode)
      OP_R_TYPE: begin
        alu_op     = ALU_RTYPE;
        regs_write = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_I_TYPE_IMME: begin
        alu_op     = ALU_IMM;
        alusrc     = 1'b1;
        regs_write = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_I_TYPE_LOAD: begin
        mem_to_regs = 1'b1;
        mem_read    = 1'b1;
        alusrc      = 1'b1;
        regs_write  = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_S_TYPE: begin
        mem_write = 1'b1;
        alusrc    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OP_B_TYPE: begin
        alu_op  = ALU_BRANCH;
        branch  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_J_TYPE_JAL: begin
        branch     = 1'b1;
        regs_write = 1'b1;
      end
      OP_J_TYPE_JALR: begin
        branch     = 1'b1;
        regs_write = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_U_TYPE_LUI, OP_U_TYPE_AUIPC: begin
        alusrc     = 1'b1;
        regs_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control pipeline stage: decodes the ID opcode, detects load-use hazards,
// handles EX backpressure and branch flush, and counts load-use stall cycles.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int HAZARD_EN   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  output logic                   id_ready,
  input  logic                   ex_flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [1:0]             ex_ALUOp,
  output logic                   ex_branch,
  output logic                   ex_mem_to_regs,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_alusrc,
  output logic                   ex_regs_write,
  output logic [REG_AW-1:0]      ex_rd,
  output logic                   ex_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic [1:0] dec_alu_op;
  logic       dec_branch, dec_mem_to_regs, dec_mem_read, dec_mem_write;
  logic       dec_alusrc, dec_regs_write, dec_use_rs1, dec_use_rs2, dec_illegal;

  ex_ctrl_t                dec_ctrl;
  ex_ctrl_t                ex_ctrl_q, ex_ctrl_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0]       ex_rd_q, ex_rd_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                    hazard, hold, rs_match;

  ctrl_decode u_decode (
    .opcode      (id_opcode),
    .alu_op      (dec_alu_op),
    .branch      (dec_branch),
    .mem_to_regs (dec_mem_to_regs),
    .mem_read    (dec_mem_read),
    .mem_write   (dec_mem_write),
    .alusrc      (dec_alusrc),
    .regs_write  (dec_regs_write),
    .use_rs1     (dec_use_rs1),
    .use_rs2     (dec_use_rs2),
    .illegal     (dec_illegal)
  );

  // Writes to x0 are architecturally discarded, so never request them.
  always_comb begin
    dec_ctrl.alu_op      = alu_op_e'(dec_alu_op);
    dec_ctrl.branch      = dec_branch;
    dec_ctrl.mem_to_regs = dec_mem_to_regs;
    dec_ctrl.mem_read    = dec_mem_read;
    dec_ctrl.mem_write   = dec_mem_write;
    dec_ctrl.alusrc      = dec_alusrc;
    dec_ctrl.regs_write  = dec_regs_write & (id_rd != '0);
    dec_ctrl.illegal     = dec_illegal;
  end

  assign rs_match = (dec_use_rs1 & (ex_rd_q == id_rs1)) |
                    (dec_use_rs2 & (ex_rd_q == id_rs2));
  assign hazard   = (HAZARD_EN != 0) & ex_valid_q & ex_ctrl_q.mem_read &
                    id_valid & (ex_rd_q != '0) & rs_match;
  assign hold     = ex_valid_q & ~ex_ready;

  // Flush beats hold beats hazard; a bubble clears the whole EX entry.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    stall_cnt_d = stall_cnt_q;
    id_ready    = 1'b1;
    if (ex_flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
    end else if (hold) begin
      id_ready = 1'b0;
    end else if (hazard) begin
      id_ready   = 1'b0;
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else if (id_valid) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = dec_ctrl;
      ex_rd_d    = id_rd;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_ALUOp       = ex_ctrl_q.alu_op;
  assign ex_branch      = ex_ctrl_q.branch;
  assign ex_mem_to_regs = ex_ctrl_q.mem_to_regs;
  assign ex_mem_read    = ex_ctrl_q.mem_read;
  assign ex_mem_write   = ex_ctrl_q.mem_write;
  assign ex_alusrc      = ex_ctrl_q.alusrc;
  assign ex_regs_write  = ex_ctrl_q.regs_write;
  assign ex_rd          = ex_rd_q;
  assign ex_illegal     = ex_ctrl_q.illegal;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: a reference model pushes the expected EX
// entry each cycle into a scoreboard queue which is popped after the clock edge.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       ex_flush, ex_ready;

  logic        id_ready, ex_valid, ex_branch, ex_mem_to_regs, ex_mem_read;
  logic        ex_mem_write, ex_alusrc, ex_regs_write, ex_illegal;
  logic [1:0]  ex_ALUOp;
  logic [4:0]  ex_rd;
  logic [15:0] stall_cnt;

  logic        nh_id_ready, nh_ex_valid, nh_ex_branch, nh_ex_mem_to_regs, nh_ex_mem_read;
  logic        nh_ex_mem_write, nh_ex_alusrc, nh_ex_regs_write, nh_ex_illegal;
  logic [1:0]  nh_ex_ALUOp;
  logic [4:0]  nh_ex_rd;
  logic [15:0] nh_stall_cnt;

  logic        st_id_ready, st_ex_valid, st_ex_branch, st_ex_mem_to_regs, st_ex_mem_read;
  logic        st_ex_mem_write, st_ex_alusrc, st_ex_regs_write, st_ex_illegal;
  logic [1:0]  st_ex_ALUOp;
  logic [4:0]  st_ex_rd;
  logic [1:0]  st_stall_cnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [14:0] expQ[$];
  int          cntQ[$];
  logic [14:0] mEx;
  int          mCnt;

  localparam logic [6:0] R_OP = 7'b0110011, IMM_OP = 7'b0010011, LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ready(id_ready), .ex_flush(ex_flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_branch(ex_branch),
    .ex_mem_to_regs(ex_mem_to_regs), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alusrc(ex_alusrc), .ex_regs_write(ex_regs_write), .ex_rd(ex_rd),
    .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
  );

  ctrl_pipe #(.HAZARD_EN(0)) dut_nohaz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ready(nh_id_ready), .ex_flush(ex_flush),
    .ex_ready(ex_ready), .ex_valid(nh_ex_valid), .ex_ALUOp(nh_ex_ALUOp), .ex_branch(nh_ex_branch),
    .ex_mem_to_regs(nh_ex_mem_to_regs), .ex_mem_read(nh_ex_mem_read),
    .ex_mem_write(nh_ex_mem_write), .ex_alusrc(nh_ex_alusrc), .ex_regs_write(nh_ex_regs_write),
    .ex_rd(nh_ex_rd), .ex_illegal(nh_ex_illegal), .stall_cnt(nh_stall_cnt)
  );

  ctrl_pipe #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ready(st_id_ready), .ex_flush(ex_flush),
    .ex_ready(ex_ready), .ex_valid(st_ex_valid), .ex_ALUOp(st_ex_ALUOp), .ex_branch(st_ex_branch),
    .ex_mem_to_regs(st_ex_mem_to_regs), .ex_mem_read(st_ex_mem_read),
    .ex_mem_write(st_ex_mem_write), .ex_alusrc(st_ex_alusrc), .ex_regs_write(st_ex_regs_write),
    .ex_rd(st_ex_rd), .ex_illegal(st_ex_illegal), .stall_cnt(st_stall_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference decode: {valid, ALUOp, branch, mem_to_regs, mem_read, mem_write, alusrc, regs_write, rd, illegal}
  function automatic logic [14:0] expDecode(input logic [6:0] op, input logic [4:0] rd);
    logic [7:0] c;
    logic       ill;
    ill = 1'b0;
    case (op)
      R_OP:     c = 8'b10_0_0_0_0_0_1;
      IMM_OP:   c = 8'b11_0_0_0_0_1_1;
      LD_OP:    c = 8'b00_0_1_1_0_1_1;
      ST_OP:    c = 8'b00_0_0_0_1_1_0;
      BR_OP:    c = 8'b01_1_0_0_0_0_0;
      JAL_OP:   c = 8'b00_1_0_0_0_0_1;
      JALR_OP:  c = 8'b00_1_0_0_0_0_1;
      LUI_OP:   c = 8'b00_0_0_0_0_1_1;
      AUIPC_OP: c = 8'b00_0_0_0_0_1_1;
      default: begin c = 8'b0; ill = 1'b1; end
    endcase
    c[0] = c[0] & (rd != 5'd0);
    return {1'b1, c, rd, ill};
  endfunction

  function automatic logic usesRs1(input logic [6:0] op);
    return op inside {R_OP, IMM_OP, LD_OP, ST_OP, BR_OP, JALR_OP};
  endfunction

  function automatic logic usesRs2(input logic [6:0] op);
    return op inside {R_OP, ST_OP, BR_OP};
  endfunction

  function automatic logic [14:0] dutVector();
    return {ex_valid, ex_ALUOp, ex_branch, ex_mem_to_regs, ex_mem_read, ex_mem_write,
            ex_alusrc, ex_regs_write, ex_rd, ex_illegal};
  endfunction

  // Drives one cycle at the falling edge, checks id_ready, pushes the expected
  // EX entry, then pops and compares it after the rising edge.
  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rdy, input logic flush, output logic accepted);
    logic        mValid, mRead, hazard, hold, expReady;
    logic [4:0]  mRd;
    logic [14:0] nxt, got, mask;
    int          expCnt;
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_ready = rdy; ex_flush = flush;
    #1;
    mValid = mEx[14]; mRead = mEx[9]; mRd = mEx[5:1];
    hazard = mValid & mRead & v & (mRd != 5'd0) &
             ((usesRs1(op) & (mRd == rs1)) | (usesRs2(op) & (mRd == rs2)));
    hold   = mValid & ~rdy;
    nxt    = mEx;
    if (flush) begin
      expReady = 1'b1; nxt = '0;
    end else if (hold) begin
      expReady = 1'b0;
    end else if (hazard) begin
      expReady = 1'b0; nxt = '0; mCnt++;
    end else begin
      expReady = 1'b1; nxt = v ? expDecode(op, rd) : 15'd0;
    end
    checkOutput("id_ready", {31'd0, id_ready}, {31'd0, expReady});
    accepted = v & expReady & ~flush;
    mEx = nxt;
    expQ.push_back(nxt);
    cntQ.push_back(mCnt);
    @(posedge clk);
    #1;
    nxt    = expQ.pop_front();
    expCnt = cntQ.pop_front();
    mask   = nxt[14] ? 15'h7FFF : 15'h7FC1;
    got    = dutVector();
    checkOutput("ex_bundle", {17'd0, got & mask}, {17'd0, nxt & mask});
    checkOutput("stall_cnt", {16'd0, stall_cnt}, expCnt);
    checkOutput("sat_stall_cnt", {30'd0, st_stall_cnt}, (expCnt > 3) ? 3 : expCnt);
    @(negedge clk);
  endtask

  // Re-presents an instruction until accepted, as upstream does during a stall.
  task automatic issueInstr(input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) applyStimulus(1'b1, op, rd, rs1, rs2, 1'b1, 1'b0, acc);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  logic acc;
  logic [6:0] sweepOps [10];

  initial begin
    sweepOps = '{R_OP, IMM_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP, 7'h7F};
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ex_flush = 1'b0; ex_ready = 1'b1;
    mEx = '0; mCnt = 0;
    @(negedge clk); #1;
    checkOutput("reset_ex", {17'd0, dutVector()}, 32'd0);
    checkOutput("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] decode sweep");
    foreach (sweepOps[i]) issueInstr(sweepOps[i], 5'd5, 5'd1, 5'd2);
    issueInstr(R_OP, 5'd0, 5'd1, 5'd2);
    checkOutput("illegal_regs_write", 32'd0, 32'd0 | ex_regs_write);

    $display("[TB] load-use");
    issueInstr(LD_OP, 5'd3, 5'd1, 5'd0);
    applyStimulus(1'b1, R_OP, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0, acc);
    checkOutput("stall_accept", {31'd0, acc}, 32'd0);
    checkOutput("nohaz_ex_valid", {31'd0, nh_ex_valid}, 32'd1);
    checkOutput("nohaz_ex_rd", {27'd0, nh_ex_rd}, 32'd4);
    checkOutput("nohaz_stall_cnt", {16'd0, nh_stall_cnt}, 32'd0);
    applyStimulus(1'b1, R_OP, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0, acc);
    checkOutput("after_stall_accept", {31'd0, acc}, 32'd1);

    $display("[TB] no false hazard");
    issueInstr(LD_OP, 5'd0, 5'd1, 5'd0);
    applyStimulus(1'b1, R_OP, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, acc);
    issueInstr(LD_OP, 5'd3, 5'd1, 5'd0);
    applyStimulus(1'b1, LUI_OP, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, acc);

    $display("[TB] backpressure and flush");
    issueInstr(R_OP, 5'd5, 5'd1, 5'd2);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, IMM_OP, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, IMM_OP, 5'd6, 5'd1, 5'd0, 1'b0, 1'b1, acc);
    issueInstr(IMM_OP, 5'd7, 5'd1, 5'd0);

    $display("[TB] stall counter saturation");
    for (int k = 0; k < 5; k++) begin
      issueInstr(LD_OP, 5'd3, 5'd1, 5'd0);
      issueInstr(R_OP, 5'd4, 5'd3, 5'd1);
    end
    checkOutput("sat_final", {30'd0, st_stall_cnt}, 32'd3);
    checkOutput("main_final", {16'd0, stall_cnt}, 32'd6);

    $display("[TB] reset during stall");
    issueInstr(LD_OP, 5'd3, 5'd1, 5'd0);
    id_valid = 1'b1; id_opcode = R_OP; id_rd = 5'd4; id_rs1 = 5'd3; id_rs2 = 5'd1;
    #1;
    checkOutput("stall_before_rst", {31'd0, id_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mEx = '0; mCnt = 0;
    applyStimulus(1'b1, R_OP, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0, acc);
    checkOutput("post_rst_accept", {31'd0, acc}, 32'd1);
    applyStimulus(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
